ws2812_frame_ctrl: RTL and testbench
====================================

WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning number of pixels per frame (1..1024).
REQ-002 SHALL have parameter BIT_CYCLES, default 62, meaning clk cycles per encoded bit.
REQ-003 SHALL have parameter T0H_CYCLES, default 20, meaning high time of a '0' bit in clk cycles.
REQ-004 SHALL have parameter T1H_CYCLES, default 40, meaning high time of a '1' bit in clk cycles.
REQ-005 SHALL have parameter LATCH_CYCLES, default 2500, meaning low latch gap after the frame (50 us at 50 MHz).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, 50 MHz, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: frame request, sampled on the rising edge of clk.
REQ-009 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-010 SHALL have port pix_rd, output, 1 bit: one-cycle pixel read strobe.
REQ-011 SHALL have port pix_addr, output, width max(1,clog2(NUM_LEDS)): pixel index being read.
REQ-012 SHALL have port pix_data, input, 24 bits: GRB pixel, valid the cycle after pix_rd.
REQ-013 SHALL have port dout, output, 1 bit: serial WS2812 line.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at end of latch gap.

Function
REQ-015 SHALL implement states IDLE, FETCH, LOAD, SEND, LATCH.
REQ-016 In IDLE with start=1, SHALL go to FETCH next cycle and assert busy from that cycle.
REQ-017 FETCH SHALL last 1 cycle with pix_rd=1 and pix_addr=0, then go to LOAD.
REQ-018 LOAD SHALL last 1 cycle, capture pix_data into the 24-bit shift register, and enter SEND with pixel index 0, bit index 23, cycle counter 0.
REQ-019 In SEND, dout SHALL be 1 while cycle counter < T1H_CYCLES when the current bit is 1, or < T0H_CYCLES when it is 0; otherwise 0.
REQ-020 The cycle counter SHALL count 0..BIT_CYCLES-1 and wrap; on wrap the bit index decrements, sending MSB (bit 23) first.
REQ-021 At bit index 23, cycle 0 of pixel k with k < NUM_LEDS-1, SHALL assert pix_rd for 1 cycle with pix_addr=k+1 and capture pix_data the next cycle into a hold register.
REQ-022 At the end of bit 0 of pixel k < NUM_LEDS-1, SHALL load the shift register from the hold register with no gap cycles, so bit periods are contiguous across pixels.
REQ-023 At the end of bit 0 of pixel NUM_LEDS-1, SHALL enter LATCH.
REQ-024 No pix_rd SHALL issue beyond address NUM_LEDS-1, giving exactly NUM_LEDS strobes per frame.
REQ-025 LATCH SHALL hold dout=0 for exactly LATCH_CYCLES cycles.
REQ-026 Done SHALL pulse in the last LATCH cycle; busy SHALL fall and the FSM SHALL be in IDLE on the next cycle.
REQ-027 Start SHALL be ignored while busy=1, with no queuing.
REQ-028 Start held high SHALL begin a new frame in the first IDLE cycle after done, i.e. back-to-back frames.
REQ-029 A frame SHALL last 2 + 24*NUM_LEDS*BIT_CYCLES + LATCH_CYCLES cycles from FETCH entry to IDLE.
REQ-030 Parameters SHALL satisfy 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; elaboration SHALL fail otherwise.
REQ-031 Counters SHALL be sized to hold BIT_CYCLES-1, LATCH_CYCLES-1 and NUM_LEDS-1 without overflow.

Reset
REQ-032 On rst=1, state SHALL be IDLE immediately (asynchronously), regardless of clk.
REQ-033 On rst=1, dout, busy, pix_rd and done SHALL be 0, and pix_addr, all counters, the shift register and the hold register SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no done pulse, and dout SHALL fall within the same cycle.
REQ-035 After reset release, the first start SHALL begin at pixel 0.

Verification
REQ-036 Defaults, NUM_LEDS=1, pix_data=24'hFF0000 -> dout shows eight 40-high/22-low periods then sixteen 20-high/42-low periods, 2500 low cycles, done once at cycle 2+1488+2500-1 after FETCH entry.
REQ-037 NUM_LEDS=3, memory {0xAAAAAA,0x555555,0x000001} -> pix_rd at addr 0,1,2 only, 72 contiguous 62-cycle periods, last bit long-high.
REQ-038 Start pulses during SEND and LATCH -> ignored: exactly one frame and one done.
REQ-039 Start held high for 3 frames -> three done pulses, each next FETCH the cycle after IDLE re-entry.
REQ-040 rst asserted at bit 10 of pixel 1 -> dout, busy, pix_rd=0 same cycle, no done; next start refetches addr 0.
REQ-041 T0H_CYCLES=40, T1H_CYCLES=20 -> elaboration error.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame controller: fetches NUM_LEDS GRB pixels and serialises them MSB first,
// then holds the line low for the latch gap. The next pixel is prefetched while the current one is sent.
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_CYCLES   = 62,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int LATCH_CYCLES = 2500,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic [23:0]   pix_data,
  output logic          dout,
  output logic          done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYCLES);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(NUM_LEDS - 1);

  if (NUM_LEDS < 1 || NUM_LEDS > 1024 || T0H_CYCLES <= 0 || T1H_CYCLES <= T0H_CYCLES ||
      BIT_CYCLES <= T1H_CYCLES || LATCH_CYCLES < 1) begin : g_param_err
    $error("ws2812_frame_ctrl: illegal parameters (need 0 < T0H < T1H < BIT_CYCLES)");
  end

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [23:0]     sh_q, sh_d;
  logic [23:0]     hold_q, hold_d;
  logic            rd_dly_q, rd_dly_d;
  logic            busy_q, busy_d;
  logic            pix_rd_q, pix_rd_d;
  logic [AW-1:0]   pix_addr_q, pix_addr_d;
  logic            dout_q, dout_d;
  logic            done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    pix_d      = pix_q;
    lat_d      = lat_q;
    sh_d       = sh_q;
    rd_dly_d   = pix_rd_q;
    // read data arrives the cycle after the strobe
    hold_d     = rd_dly_q ? pix_data : hold_q;
    busy_d     = busy_q;
    pix_rd_d   = 1'b0;
    pix_addr_d = pix_addr_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = FETCH;
          busy_d     = 1'b1;
          pix_rd_d   = 1'b1;
          pix_addr_d = '0;
          pix_d      = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        sh_d    = pix_data;
        state_d = SEND;
        cnt_d   = '0;
        bit_d   = 5'd23;
        pix_d   = '0;
      end
      SEND: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd0) begin
            if (pix_q == PIX_LAST) begin
              state_d = LATCH;
              lat_d   = '0;
            end else begin
              sh_d  = hold_q;
              pix_d = pix_q + AW'(1);
              bit_d = 5'd23;
            end
          end else begin
            bit_d = bit_q - 5'd1;
            sh_d  = sh_q << 1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH: begin
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    if (state_d == SEND && bit_d == 5'd23 && cnt_d == '0 && pix_d != PIX_LAST) begin
      pix_rd_d   = 1'b1;
      pix_addr_d = pix_d + AW'(1);
    end
    dout_d = (state_d == SEND) && (cnt_d < (sh_d[23] ? T1H_C : T0H_C));
    done_d = (state_d == LATCH) && (lat_d == LAT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      pix_q      <= '0;
      lat_q      <= '0;
      sh_q       <= '0;
      hold_q     <= '0;
      rd_dly_q   <= 1'b0;
      busy_q     <= 1'b0;
      pix_rd_q   <= 1'b0;
      pix_addr_q <= '0;
      dout_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      pix_q      <= pix_d;
      lat_q      <= lat_d;
      sh_q       <= sh_d;
      hold_q     <= hold_d;
      rd_dly_q   <= rd_dly_d;
      busy_q     <= busy_d;
      pix_rd_q   <= pix_rd_d;
      pix_addr_q <= pix_addr_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign pix_rd   = pix_rd_q;
  assign pix_addr = pix_addr_q;
  assign dout     = dout_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed/randomized bench for ws2812_frame_ctrl: each frame's waveform, read strobes,
// done and busy are compared cycle by cycle against an arithmetic model of the frame.
module tb_ws2812_frame_ctrl;

  localparam int N     = 3;
  localparam int BC    = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int LC    = 20;
  localparam int FRAME = 2 + 24 * N * BC + LC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, pix_rd, dout, done;
  logic [1:0]  pix_addr;
  logic [23:0] pix_data = '0;

  logic [23:0] mem [4];
  logic [23:0] px  [N];

  int checks = 0;
  int errors = 0;

  ws2812_frame_ctrl #(
    .NUM_LEDS(N), .BIT_CYCLES(BC), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .LATCH_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .pix_rd(pix_rd),
    .pix_addr(pix_addr), .pix_data(pix_data), .dout(dout), .done(done)
  );

  always #5 clk = ~clk;

  // pixel memory with one cycle read latency
  always @(posedge clk) if (pix_rd === 1'b1) pix_data <= mem[pix_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // expected line level at cycle i counted from FETCH entry
  function automatic logic exp_dout(input int i);
    int j, p, b, c;
    j = i - 2;
    if (i < 2 || j >= 24 * N * BC) return 1'b0;
    p = j / (24 * BC);
    b = 23 - (j % (24 * BC)) / BC;
    c = j % BC;
    return (c < (px[p][b] ? T1H : T0H));
  endfunction

  task automatic idle_chk(input string tag);
    int act = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || pix_rd !== 1'b0) act++;
      @(negedge clk);
    end
    chk({tag, " idle"}, act, 0);
  endtask

  task automatic run_frame(input string tag, input bit first, input bit keep, input bit spur,
                           input bit rnd, input logic [23:0] d0, d1, d2);
    int werr = 0, rderr = 0, derr = 0, berr = 0, nrd = 0, ndone = 0;
    if (rnd) for (int k = 0; k < N; k++) px[k] = 24'($urandom);
    else begin px[0] = d0; px[1] = d1; px[2] = d2; end
    for (int k = 0; k < N; k++) mem[k] = px[k];
    if (first) begin
      start = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i <= FRAME; i++) begin
      int j, eaddr;
      logic erd;
      j = i - 2;
      erd = 1'b0; eaddr = 0;
      if (i == 0) erd = 1'b1;
      else if (j >= 0 && j % (24 * BC) == 0 && j / (24 * BC) < N - 1) begin
        erd = 1'b1; eaddr = j / (24 * BC) + 1;
      end
      if (dout !== exp_dout(i)) werr++;
      if (pix_rd !== erd || (erd && int'(pix_addr) != eaddr)) rderr++;
      if (done !== (i == FRAME - 1)) derr++;
      if (busy !== (i < FRAME)) berr++;
      if (pix_rd === 1'b1) nrd++;
      if (done === 1'b1) ndone++;
      if (!keep) start = spur && (i == 100 || i == FRAME - 3);
      @(negedge clk);
    end
    chk({tag, " wave"}, werr, 0);
    chk({tag, " rd"}, rderr, 0);
    chk({tag, " done"}, derr, 0);
    chk({tag, " busy"}, berr, 0);
    chk({tag, " nrd"}, nrd, N);
    chk({tag, " ndone"}, ndone, 1);
  endtask

  initial begin
    int ri;
    for (int k = 0; k < 4; k++) mem[k] = '0;
    for (int k = 0; k < N; k++) px[k] = '0;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst dout", int'(dout), 0);
    chk("rst pix_rd", int'(pix_rd), 0);
    chk("rst done", int'(done), 0);
    chk("rst pix_addr", int'(pix_addr), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame("pattern", 1, 0, 0, 0, 24'hAAAAAA, 24'h555555, 24'h000001);
    idle_chk("pattern");
    run_frame("rand1", 1, 0, 0, 1, '0, '0, '0);
    run_frame("spurious", 1, 0, 1, 1, '0, '0, '0);
    idle_chk("spurious");

    start = 1'b1;
    run_frame("b2b0", 1, 1, 0, 1, '0, '0, '0);
    run_frame("b2b1", 0, 1, 0, 1, '0, '0, '0);
    run_frame("b2b2", 0, 0, 0, 1, '0, '0, '0);
    idle_chk("b2b");

    // abort at cycle 0 of bit 10 of pixel 1
    for (int k = 0; k < N; k++) begin px[k] = 24'($urandom); mem[k] = px[k]; end
    ri = 2 + 24 * BC + 13 * BC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < ri; i++) @(negedge clk);
    chk("pre-abort dout", int'(dout), int'(exp_dout(ri)));
    rst = 1'b1;
    #1;
    chk("abort dout", int'(dout), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort pix_rd", int'(pix_rd), 0);
    chk("abort done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk("abort");
    run_frame("post_rst", 1, 0, 0, 1, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
